// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: PC owner and in-order fetch queue between instruction memory and decode.
// Define FETCH_DELAY_SLOT_EN to preserve the branch delay slot on redirect.
module mips_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(32'hBFC0_0000),
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDRESS = ADDR_WIDTH'(32'h0000_0000),
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    output logic [ADDR_WIDTH-1:0] instr_address,
    input  logic [DATA_WIDTH-1:0] instr_readdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pc_plus_four,
    input  logic                  deq_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  active
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q [QUEUE_DEPTH];
    logic [PW-1:0] head, tail, head_n, tail_n;
    logic [CW-1:0] count, count_n;
    logic pop, redir, fetch, push;

    assign instr_address    = pc;
    assign out_valid        = count != '0;
    assign out_instr        = instr_q[head];
    assign out_pc           = pc_q[head];
    assign out_pc_plus_four = pc_q[head] + ADDR_WIDTH'(4);

`ifdef FETCH_DELAY_SLOT_EN
    logic keep_slot;
    // An entry behind the branch is the delay slot; otherwise the current fetch becomes it.
    always_comb begin
        pop       = out_valid && deq_ready;
        redir     = redirect_valid && pop;
        fetch     = active && pc != HALT_ADDRESS && (count < CW'(QUEUE_DEPTH) || pop);
        keep_slot = count >= CW'(2);
        push      = fetch && !(redir && keep_slot);
        head_n    = head + PW'(pop);
        tail_n    = (redir && keep_slot) ? head + PW'(2) : tail + PW'(push);
        count_n   = redir ? CW'(keep_slot || push) : count + CW'(push) - CW'(pop);
    end
`else
    always_comb begin
        pop     = out_valid && deq_ready;
        redir   = redirect_valid && pop;
        fetch   = active && pc != HALT_ADDRESS && (count < CW'(QUEUE_DEPTH) || pop);
        push    = fetch && !redir;
        head_n  = redir ? tail : head + PW'(pop);
        tail_n  = tail + PW'(push);
        count_n = redir ? '0 : count + CW'(push) - CW'(pop);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_VECTOR;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            active <= 1'b1;
        end else if (clk_enable) begin
            pc     <= redir ? redirect_target : push ? pc + ADDR_WIDTH'(4) : pc;
            head   <= head_n;
            tail   <= tail_n;
            count  <= count_n;
            active <= active && !(pc == HALT_ADDRESS && count == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && clk_enable && push) begin
            instr_q[tail] <= instr_readdata;
            pc_q[tail]    <= pc;
        end
    end
endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Parametrised instruction-fetch stage for the pipelined MIPS core. It owns the program counter, drives the Harvard instruction bus, and buffers fetched words in a small in-order queue so that decode back-pressure does not stall the bus. It accepts branch/jump redirects from decode with optional branch-delay-slot preservation, and detects the halt address to drive `active`. It sits between the instruction memory port and the decode stage.

## Interface
- `ADDR_WIDTH`, 32: PC and instruction-address width.
- `DATA_WIDTH`, 32: instruction word width.
- `RESET_VECTOR`, 32'hBFC0_0000: PC value after reset.
- `HALT_ADDRESS`, 32'h0000_0000: a PC equal to this value is never fetched and halts the unit.
- `QUEUE_DEPTH`, 2: fetch-queue entries; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `clk_enable` in 1: when 0, all state holds and no push, pop or redirect takes effect.
- `instr_address` out ADDR_WIDTH: current PC, driven combinationally from the PC register.
- `instr_readdata` in DATA_WIDTH: combinational read data for `instr_address`.
- `out_valid` out 1: queue head is valid.
- `out_instr` out DATA_WIDTH: head instruction.
- `out_pc` out ADDR_WIDTH: head PC.
- `out_pc_plus_four` out ADDR_WIDTH: `out_pc` + 4, modulo 2^ADDR_WIDTH.
- `deq_ready` in 1: decode accepts the head this cycle.
- `redirect_valid` in 1: redirect request from decode.
- `redirect_target` in ADDR_WIDTH: new PC.
- `active` out 1: high until halt.

## Operation
- Outputs after reset: PC = RESET_VECTOR, count = 0, `out_valid` = 0, `active` = 1.
- Queue contents are X until written; the bench masks `out_*` when `out_valid` = 0.
- Pop condition: `out_valid && deq_ready`.
- Fetch condition: `active && PC != HALT_ADDRESS && (count < QUEUE_DEPTH || pop)`.
  - On fetch, `{instr_readdata, PC}` is pushed to the tail.
  - PC advances by 4 (wraps mod 2^ADDR_WIDTH).
- If the queue is full and there is no pop, PC holds and `instr_address` stays stable.
- Simultaneous push and pop: count is unchanged and ordering is preserved.
- `redirect_valid` is legal only in a cycle where pop = 1, i.e. decode is consuming the branch. Other uses are a protocol error; behaviour is undefined and flagged by a bench assertion.
- Redirect has priority over normal sequential advance: PC ← `redirect_target`.
  - The queue is flushed, except for the delay slot (see Configuration).
- Halt: when PC == HALT_ADDRESS and count == 0, `active` goes low on the next edge and stays low until reset.
  - Queued entries already ahead of the halt are still delivered.
- Reset mid-operation flushes the queue and reloads RESET_VECTOR regardless of `clk_enable`.

## Timing
- Fetch-to-decode latency: 1 cycle. A word fetched at edge N is presented as head after edge N.
- Throughput: 1 instruction/cycle while `deq_ready` = 1.
- First `out_valid` occurs in the second cycle after reset is released, with `out_pc` = RESET_VECTOR.
- `out_*` are registered state. `instr_address` is a register output with no combinational path from any input.
- A redirect in cycle N puts `redirect_target` on `instr_address` in cycle N+1.
- With the delay slot held or fetched, the target reaches the head in cycle N+2.
- `active` falls 1 cycle after the halt condition is met.

## Configuration
- `FETCH_DELAY_SLOT_EN` defined:
  - On redirect, the entry directly behind the popped branch (the delay slot) is kept and all others are flushed.
  - If no such entry exists and PC != HALT_ADDRESS, the sequential fetch at PC is still pushed that cycle as the delay slot, then PC ← target.
- `FETCH_DELAY_SLOT_EN` undefined:
  - Redirect flushes the entire queue.
  - No push occurs in the redirect cycle.

## Test plan
- Reset with `deq_ready` = 1 and memory returning the address as data:
  - `instr_address` = 0xBFC00000 and `active` = 1 during reset.
  - After release, the head sequence is 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles.
- `deq_ready` = 0 for 4 cycles with QUEUE_DEPTH = 2:
  - count saturates at 2 and `instr_address` holds at 0xBFC00008.
  - After release, the heads are 0xBFC00000, 0xBFC00004, 0xBFC00008 with no loss or duplication.
- Redirect to 0x00001000 while popping the branch at 0xBFC00004, macro undefined: the next head is 0x00001000.
- Same redirect with `FETCH_DELAY_SLOT_EN`: the next heads are 0xBFC00008 then 0x00001000. Repeat with the queue holding only the branch; the result is the same.
- Redirect to 0x00000000:
  - No head with `out_pc` = 0 is ever presented.
  - `active` falls 1 cycle after the queue empties, after the delay slot is delivered when the macro is defined.
- Mid-stream checks:
  - `clk_enable` = 0 for 3 cycles: PC, queue and outputs are frozen.
  - Then `reset` for 1 cycle with a full queue: `out_valid` = 0 and PC = 0xBFC00000 on the next cycle.
